// File: rtl/ps2_direction_pkg.sv
// Shared PS/2 scan-code constants, direction one-hot encodings and key decode helper.
// Used by the keyboard direction decoder and by the plane-position logic.
// Contents: scan codes, direction encodings, key index enum, receiver FSM states.
package ps2_direction_pkg;

    // Scan codes (set 2)
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;  // arrow keys, only valid after E0
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;  // WASD aliases, valid with or without E0
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Direction one-hot encodings
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT} dir_key_e;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

    typedef struct packed {
        logic     is_dir;
        dir_key_e key;
        logic     is_space;
    } key_t;

    function automatic logic [3:0] dir_onehot(input dir_key_e k);
        logic [3:0] d;
        case (k)
            KEY_UP:    d = DIR_UP;
            KEY_DOWN:  d = DIR_DOWN;
            KEY_LEFT:  d = DIR_LEFT;
            KEY_RIGHT: d = DIR_RIGHT;
            default:   d = DIR_NONE;
        endcase
        return d;
    endfunction

    // Classify a non-prefix byte; ext is the E0 flag in effect for it.
    function automatic key_t decode_key(input logic [7:0] code, input logic ext);
        key_t k;
        k = '0;
        if ((ext && code == SC_UP) || code == SC_W) begin
            k.is_dir = 1'b1;
            k.key    = KEY_UP;
        end else if ((ext && code == SC_DOWN) || code == SC_S) begin
            k.is_dir = 1'b1;
            k.key    = KEY_DOWN;
        end else if ((ext && code == SC_LEFT) || code == SC_A) begin
            k.is_dir = 1'b1;
            k.key    = KEY_LEFT;
        end else if ((ext && code == SC_RIGHT) || code == SC_D) begin
            k.is_dir = 1'b1;
            k.key    = KEY_RIGHT;
        end else if (!ext && code == SC_SPACE) begin
            k.is_space = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_direction_if.sv
// PS/2 line inputs and decoded direction/fire outputs bundled as one port.
// master: drives the PS/2 lines, observes outputs; slave: the decoder.
// Signals: ps2_clk, ps2_data, direction[3:0], boom, frame_err.
interface ps2_direction_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] direction;
    logic       boom;
    logic       frame_err;

    modport master (output ps2_clk, ps2_data, input direction, boom, frame_err);
    modport slave  (input ps2_clk, ps2_data, output direction, boom, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the lines, samples on ps2_clk falling edges, checks framing.
// Latency: rx_byte/byte_valid 3 clk after the stop-bit falling edge at the pins. No backpressure.
// Ports: clk, rst, ps2_clk, ps2_data in; rx_byte[7:0], byte_valid (1-cycle), err (1-cycle) out.
module ps2_rx
    import ps2_direction_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic fall, timeout;

    rx_state_e   state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [TW-1:0] to_q;
    logic        vld_d, err_d;

    // Synchronizers idle high so reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall    = clk_prev & ~clk_s2;
    // A sampling event on the same cycle wins over the timeout.
    assign timeout = (state_q != IDLE) && (to_q == TW'(TIMEOUT)) && !fall;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {dat_s2, shift_q[7:1]};   // LSB arrives first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2 && (^{shift_q, par_q})) vld_d = 1'b1;
                    else                               err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_q       <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            byte_valid <= vld_d;
            err        <= err_d;
            if (vld_d) rx_byte <= shift_q;
            if (fall)                     to_q <= '0;
            else if (to_q != TW'(TIMEOUT)) to_q <= to_q + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_direction.sv
// Keyboard-to-move decoder: PS/2 scan codes to a one-hot direction and a fire (space) flag.
// Latency: direction/boom update 4 clk after the stop-bit falling edge. No backpressure.
// Ports: clk, rst, bus (slave: ps2_clk, ps2_data in; direction[3:0], boom, frame_err out).
module ps2_direction
    import ps2_direction_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_direction_if.slave bus
);
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_err;

    logic       ext, brk, space_held;
    logic [3:0] held;
    dir_key_e   last;
    key_t       key;
    logic [3:0] dir;

    ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .err       (rx_err)
    );

    assign key = decode_key(rx_byte, ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            held       <= '0;
            last       <= KEY_UP;
            space_held <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                // Clearing an unheld bit is harmless, so breaks need no held check.
                if (key.is_dir) begin
                    if (brk) begin
                        held[key.key] <= 1'b0;
                    end else begin
                        held[key.key] <= 1'b1;
                        last          <= key.key;
                    end
                end else if (key.is_space) begin
                    space_held <= !brk;
                end
            end
        end
    end

    // Most recent key wins while held; otherwise fall back to the lowest held bit.
    always_comb begin
        dir = DIR_NONE;
        if (held[last]) dir = dir_onehot(last);
        else            dir = held & (~held + 4'd1);
    end

    assign bus.direction = dir;
    assign bus.boom      = space_held;
    assign bus.frame_err = rx_err;
endmodule

// File: tb/tb_ps2_direction.sv
module tb_ps2_direction;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   err_cnt = 0;

    ps2_direction_if bus();

    ps2_direction #(.TIMEOUT(100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count every cycle frame_err is seen high; a clean pulse adds exactly one.
    always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

    typedef struct {
        logic [3:0] dir;
        logic       boom;
        int         errs;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        int         mode;   // 0 good, 1 bad parity, 2 bad stop
        logic [3:0] dir;
        logic       boom;
        int         errs;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic addv(input logic [7:0] c, input int m, input logic [3:0] d, input logic b, input int e);
        vec_t v;
        v.code = c; v.mode = m; v.dir = d; v.boom = b; v.errs = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        wait_clk(HALF);
        bus.ps2_clk = 1'b0;
        wait_clk(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input string name, input logic [7:0] code, input int mode,
                              input logic [3:0] dir, input logic boom, input int errs);
        exp_t e;
        int   base;
        logic par;
        e.dir = dir; e.boom = boom; e.errs = errs;
        sb.push_back(e);
        base = err_cnt;
        par = ~^code;
        if (mode == 1) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        bus.ps2_data = (mode == 2) ? 1'b0 : 1'b1;
        wait_clk(HALF);
        bus.ps2_clk = 1'b0;
        wait_clk(4);
        e = sb.pop_front();
        check({name, " dir"}, int'(bus.direction), int'(e.dir));
        check({name, " boom"}, int'(bus.boom), int'(e.boom));
        wait_clk(HALF - 4);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_clk(HALF);
        check({name, " err"}, err_cnt - base, e.errs);
    endtask

    initial begin
        int base;
        logic [7:0] c;

        // code, mode, direction, boom, error pulses
        addv(8'hE0, 0, 4'b0000, 0, 0);
        addv(8'h75, 0, 4'b0001, 0, 0);
        addv(8'hE0, 0, 4'b0001, 0, 0);
        addv(8'hF0, 0, 4'b0001, 0, 0);
        addv(8'h75, 0, 4'b0000, 0, 0);
        addv(8'h1C, 0, 4'b0100, 0, 0);
        addv(8'h23, 0, 4'b1000, 0, 0);
        addv(8'hF0, 0, 4'b1000, 0, 0);
        addv(8'h23, 0, 4'b0100, 0, 0);
        addv(8'hF0, 0, 4'b0100, 0, 0);
        addv(8'h1C, 0, 4'b0000, 0, 0);
        addv(8'h1C, 0, 4'b0100, 0, 0);
        addv(8'h29, 0, 4'b0100, 1, 0);
        addv(8'hF0, 0, 4'b0100, 1, 0);
        addv(8'h29, 0, 4'b0100, 0, 0);
        addv(8'h1D, 0, 4'b0001, 0, 0);
        addv(8'h1C, 0, 4'b0100, 0, 0);
        addv(8'hF0, 0, 4'b0100, 0, 0);
        addv(8'h1C, 0, 4'b0001, 0, 0);   // last released, fall back to up
        addv(8'hF0, 0, 4'b0001, 0, 0);
        addv(8'h23, 0, 4'b0001, 0, 0);   // break of unheld key
        addv(8'hE0, 0, 4'b0001, 0, 0);
        addv(8'h29, 0, 4'b0001, 0, 0);   // E0 29 is not space
        addv(8'hF0, 0, 4'b0001, 0, 0);
        addv(8'h1D, 0, 4'b0000, 0, 0);
        addv(8'hE0, 0, 4'b0000, 0, 0);
        addv(8'h75, 1, 4'b0000, 0, 1);   // even parity discarded
        addv(8'h75, 0, 4'b0001, 0, 0);   // E0 still pending
        addv(8'hE0, 0, 4'b0001, 0, 0);
        addv(8'hF0, 0, 4'b0001, 0, 0);
        addv(8'h75, 0, 4'b0000, 0, 0);
        addv(8'h1B, 2, 4'b0000, 0, 1);   // bad stop bit
        addv(8'h1B, 0, 4'b0010, 0, 0);
        addv(8'hF0, 0, 4'b0010, 0, 0);
        addv(8'h1B, 0, 4'b0000, 0, 0);
        addv(8'hE0, 0, 4'b0000, 0, 0);
        addv(8'h74, 0, 4'b1000, 0, 0);
        addv(8'hE0, 0, 4'b1000, 0, 0);
        addv(8'hF0, 0, 4'b1000, 0, 0);
        addv(8'h74, 0, 4'b0000, 0, 0);

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        wait_clk(3);
        check("reset dir", int'(bus.direction), 0);
        check("reset boom", int'(bus.boom), 0);
        check("reset err", int'(bus.frame_err), 0);
        rst = 1'b0;
        wait_clk(5);

        for (int i = 0; i < vecs.size(); i++)
            send_frame($sformatf("v%0d", i), vecs[i].code, vecs[i].mode,
                       vecs[i].dir, vecs[i].boom, vecs[i].errs);

        // Start bit of 1 is rejected while idle
        base = err_cnt;
        ps2_bit(1'b1);
        wait_clk(5);
        check("start err", err_cnt - base, 1);
        check("start dir", int'(bus.direction), 0);

        // Partial frame abandoned after the timeout
        base = err_cnt;
        c = 8'h72;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(c[i]);
        wait_clk(150);
        check("timeout err", err_cnt - base, 1);
        send_frame("to E0", 8'hE0, 0, 4'b0000, 0, 0);
        send_frame("to 72", 8'h72, 0, 4'b0010, 0, 0);
        send_frame("rel E0", 8'hE0, 0, 4'b0010, 0, 0);
        send_frame("rel F0", 8'hF0, 0, 4'b0010, 0, 0);
        send_frame("rel 72", 8'h72, 0, 4'b0000, 0, 0);
        send_frame("pre 1C", 8'h1C, 0, 4'b0100, 0, 0);

        // Reset in the middle of the 4th data bit
        base = err_cnt;
        c = 8'h1D;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(c[i]);
        bus.ps2_data = c[3];
        wait_clk(HALF);
        bus.ps2_clk = 1'b0;
        wait_clk(HALF / 2);
        rst = 1'b1;
        wait_clk(2);
        check("rst dir", int'(bus.direction), 0);
        check("rst boom", int'(bus.boom), 0);
        check("rst err", int'(bus.frame_err), 0);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        check("rst no err pulse", err_cnt - base, 0);
        send_frame("post 1D", 8'h1D, 0, 4'b0001, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_direction.md
PS2_DIRECTION -- requirements
Module: ps2_direction

Interface
REQ-001 Parameter: TIMEOUT, default 50000, clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned.
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-005 Port: ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-006 Port: direction  output  4  one-hot move command: 0001 up, 0010 down, 0100 left, 1000 right, 0000 none.
REQ-007 Port: boom  output  1  high while the space key is held.
REQ-008 Port: frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; the sampling event is a 1-to-0 transition of synchronized ps2_clk.
REQ-010 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE: a sampled data bit of 0 goes to DATA; a sampled 1 pulses frame_err and stays in IDLE.
- DATA: takes 8 bits, LSB first, then goes to PARITY.
- PARITY: takes the odd-parity bit, then goes to STOP.
- STOP: takes the stop bit, then goes to IDLE.
REQ-011 A byte SHALL be accepted only if the parity is odd over data plus parity and the stop bit is 1; otherwise the byte is discarded and frame_err pulses.
REQ-012 A timeout counter SHALL clear on every sampling event. If it reaches TIMEOUT while the FSM is not in IDLE, the FSM returns to IDLE, the partial byte is discarded and frame_err pulses.
REQ-013 The byte decoder SHALL hold two flags, ext (after E0) and brk (after F0). Both clear after any other accepted byte.
REQ-014 Key map, where release means brk was set:
- E0 75 or 1D: up, bit0.
- E0 72 or 1B: down, bit1.
- E0 6B or 1C: left, bit2.
- E0 74 or 23: right, bit3.
- 29 with ext clear: space.
REQ-015 Unmapped codes SHALL be ignored apart from clearing the flags.
REQ-016 A held[3:0] register SHALL set a bit on make and clear it on break. Repeated makes of an already-held key are idempotent.
REQ-017 A last register SHALL record the most recently made direction key.
REQ-018 direction SHALL be:
- the one-hot of last if that key is held;
- else the lowest-index held bit;
- else 0000.
direction is never multi-hot.
REQ-019 boom SHALL equal the held state of space.
REQ-020 direction and boom SHALL update on the clk cycle after the STOP bit is accepted. Latency from the stop-bit falling edge is 4 clk cycles maximum: 2 for sync, 1 for edge detect, 1 for decode.
REQ-021 A break for a key that is not held SHALL have no effect.

Reset
REQ-022 On rst the following SHALL clear asynchronously and hold while rst is high:
- FSM to IDLE;
- shift register, bit counter, timeout counter;
- ext, brk, held, last;
- synchronizers to 1.
REQ-023 Output values during and after rst SHALL be direction=0000, boom=0, frame_err=0.
REQ-024 A frame in progress when rst asserts SHALL be lost with no error pulse.

Structure
REQ-025 Scan-code constants and direction one-hot encodings SHALL live in a shared package, also used by the plane-position logic.
REQ-026 The frame receiver SHALL be a sub-module, ps2_rx, with outputs byte[7:0], byte_valid (1-cycle pulse) and err. Key decoding stays in ps2_direction.

Verification
REQ-027 Send E0,75 -> direction=0001 within 4 clk cycles of the stop edge. Then send E0,F0,75 -> direction=0000.
REQ-028 Send 1C (left), then 23 (right) -> direction=1000. Send F0,23 -> direction=0100. Send F0,1C -> direction=0000.
REQ-029 Send 29 -> boom=1 with direction unchanged. Send F0,29 -> boom=0.
REQ-030 Send byte 75 with even parity -> one frame_err pulse and direction unchanged. The next valid frame is decoded normally.
REQ-031 Send 5 bits, then idle for TIMEOUT+1 cycles (TIMEOUT set to 100) -> one frame_err pulse and FSM in IDLE. A following E0,72 -> direction=0010.
REQ-032 Assert rst in the middle of the 4th data bit while direction=0100 -> direction=0000 and no frame_err. After release, a full 1D frame -> direction=0001.
